// File: rtl/scale_mux_rr.sv
// scale_mux_rr: N-channel selector feeding a one-entry registered output.
// Each input has a valid/ready handshake. The channel is picked either by an
// external select (fixed mode) or by a round-robin arbiter. The output
// register has its own valid/ready handshake and runs at one word per cycle
// when the sink is always ready.
// Optional build macro SCALE_MUX_RR_STATS_EN adds saturating transfer and
// stall counters (o_xfer_cnt, o_stall_cnt).
module scale_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH*WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]       i_in_valid,
  output logic [NUM_CH-1:0]       o_in_ready,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [SEL_W-1:0]        o_out_ch,
  output logic                    o_out_valid,
`ifdef SCALE_MUX_RR_STATS_EN
  output logic [15:0]             o_xfer_cnt,
  output logic [15:0]             o_stall_cnt,
`endif
  input  logic                    i_out_ready
);

  localparam int PAD_N = 1 << SEL_W;

  logic [SEL_W-1:0] last_gnt;
  logic [PAD_N-1:0] valid_pad;
  logic             load_en;
  logic             fx_found;
  logic             rr_found;
  logic [SEL_W-1:0] rr_gnt;
  logic             grant_valid;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] data_sel;
  logic             in_xfer;

  // The output register may take a new word when empty or when it is being
  // emptied on this same edge.
  assign load_en = !o_out_valid || i_out_ready;

  // Zero-extend the valids to the full select range so that an out-of-range
  // select reads as "not valid" instead of indexing past the vector.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_CH-1:0] = i_in_valid;
  end

  // Fixed-mode grant: the selected channel, only if in range and valid.
  assign fx_found = (int'(i_sel) < NUM_CH) && valid_pad[i_sel];

  // Round-robin search starting just after the last granted channel; the
  // last granted channel is visited last.
  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_gnt   = '0;
    cand     = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = (int'(last_gnt) + off) % NUM_CH;
      if (!rr_found && valid_pad[SEL_W'(cand)]) begin
        rr_found = 1'b1;
        rr_gnt   = SEL_W'(cand);
      end
    end
  end

  // Choose the grant for the active mode.
  always_comb begin
    grant_valid = 1'b0;
    gnt         = '0;
    if (i_mode) begin
      grant_valid = rr_found;
      gnt         = rr_gnt;
    end else begin
      grant_valid = fx_found;
      gnt         = i_sel;
    end
  end

  // Data multiplexer for the granted channel.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(gnt) == k) begin
        data_sel = i_in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is one-hot on the granted channel and forced low during reset.
  always_comb begin
    o_in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      o_in_ready[k] = !i_rst && load_en && grant_valid && (int'(gnt) == k);
    end
  end

  assign in_xfer = !i_rst && load_en && grant_valid;

  // Output register and round-robin pointer; a new word replaces the
  // outgoing one on the same edge, otherwise an accepted word drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_ch    <= '0;
      last_gnt    <= SEL_W'(NUM_CH - 1);
    end else begin
      if (in_xfer) begin
        o_out_data  <= data_sel;
        o_out_ch    <= gnt;
        o_out_valid <= 1'b1;
        if (i_mode) begin
          last_gnt <= gnt;
        end
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

`ifdef SCALE_MUX_RR_STATS_EN
  // Saturating counters of output transfers and back-pressured cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_xfer_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_out_valid && i_out_ready && (o_xfer_cnt != 16'hFFFF)) begin
        o_xfer_cnt <= o_xfer_cnt + 16'd1;
      end
      if (o_out_valid && !i_out_ready && (o_stall_cnt != 16'hFFFF)) begin
        o_stall_cnt <= o_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scale_mux_rr.sv
// Testbench for scale_mux_rr: a 4-channel instance checked against a small
// reference model with a scoreboard queue, plus a 3-channel instance for the
// out-of-range select and asynchronous reset cases.
module tb_scale_mux_rr;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        rst3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef SCALE_MUX_RR_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] xfer_cnt3;
  logic [15:0] stall_cnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit     m_valid;
  int     m_last;
  bit     m_xfer;
  logic [3:0] exp_ready;
  word_t  sb[$];

  always #5 clk = ~clk;

  scale_mux_rr #(.WIDTH(8), .NUM_CH(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_in_data(in_data),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_mode(mode),
    .i_sel(sel),
    .o_out_data(out_data),
    .o_out_ch(out_ch),
    .o_out_valid(out_valid),
`ifdef SCALE_MUX_RR_STATS_EN
    .o_xfer_cnt(xfer_cnt),
    .o_stall_cnt(stall_cnt),
`endif
    .i_out_ready(out_ready)
  );

  scale_mux_rr #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .i_clk(clk),
    .i_rst(rst3),
    .i_in_data(in_data3),
    .i_in_valid(in_valid3),
    .o_in_ready(in_ready3),
    .i_mode(mode3),
    .i_sel(sel3),
    .o_out_data(out_data3),
    .o_out_ch(out_ch3),
    .o_out_valid(out_valid3),
`ifdef SCALE_MUX_RR_STATS_EN
    .o_xfer_cnt(xfer_cnt3),
    .o_stall_cnt(stall_cnt3),
`endif
    .i_out_ready(out_ready3)
  );

  // Predict the grant for the inputs now applied, push the expected word and
  // advance the model to its post-edge state.
  function automatic void predict();
    bit load;
    int g;
    load = !m_valid || out_ready;
    g = -1;
    if (!mode) begin
      if (in_valid[sel]) g = int'(sel);
    end else begin
      for (int off = 1; off <= 4; off++) begin
        int c;
        c = (m_last + off) % 4;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    exp_ready = 4'b0000;
    m_xfer = 1'b0;
    if (load && g >= 0) begin
      word_t w;
      exp_ready[g] = 1'b1;
      m_xfer = 1'b1;
      w.data = in_data[g*8 +: 8];
      w.ch = 2'(g);
      sb.push_back(w);
      if (mode) m_last = g;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_last  = 3;
    m_xfer  = 1'b0;
    sb.delete();
  endfunction

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    in_data   = {8'h5A, 8'hA5, 8'h11, 8'h3C};
    in_valid  = 4'hF;
    mode      = 1'b0;
    sel       = 2'd2;
    out_ready = 1'b1;
    in_data3  = {8'h33, 8'h22, 8'h11};
    in_valid3 = 3'b111;
    mode3     = 1'b0;
    sel3      = 2'd3;
    out_ready3 = 1'b1;
    rst  = 1'b1;
    rst3 = 1'b1;
    #2;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_out: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
               out_valid, out_data, out_ch);
    end
    n_tests++;
    if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b/%b expected 0000/000", in_ready, in_ready3);
    end
    n_tests++;
    if (out_valid3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_out3: got v=%b expected 0", out_valid3);
    end
    next_edge();
    rst  = 1'b0;
    rst3 = 1'b0;
    model_reset();
  endtask

  task automatic test_fixed();
    word_t w;
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if (in_ready !== exp_ready || in_ready !== 4'b0100) begin
        n_fail++;
        $display("[TB] FAIL fixed_ready[%0d]: got %b expected 0100", i, in_ready);
      end
      next_edge();
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL fixed_valid[%0d]: got %b expected 1", i, out_valid);
      end
      if (m_xfer) begin
        w = sb.pop_front();
        n_tests++;
        if (out_data !== w.data || out_ch !== w.ch || out_data !== 8'hA5 || out_ch !== 2'd2) begin
          n_fail++;
          $display("[TB] FAIL fixed_word[%0d]: got d=%h ch=%0d expected d=A5 ch=2",
                   i, out_data, out_ch);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    word_t w;
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
      end
      next_edge();
      w = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_ch !== w.ch || out_data !== w.data) begin
        n_fail++;
        $display("[TB] FAIL rr_word[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, exp_seq[i], w.data);
      end
    end
  endtask

  task automatic test_skip_idle();
    word_t w;
    int exp_seq[6] = '{1, 3, 1, 3, 1, 1};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4) ? 4'b1010 : 4'b0010;
      settle();
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL skip_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
      end
      next_edge();
      w = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_ch !== w.ch || out_data !== w.data) begin
        n_fail++;
        $display("[TB] FAIL skip_word[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, exp_seq[i], w.data);
      end
    end
  endtask

  task automatic test_back_pressure();
    word_t w;
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    settle();
    next_edge();
    w = sb.pop_front();
    n_tests++;
    if (out_data !== 8'h3C || out_data !== w.data || out_ch !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL bp_load: got d=%h ch=%0d expected d=3C ch=0", out_data, out_ch);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) sel = 2'd1;
      if (i == 2) mode = 1'b1;
      settle();
      n_tests++;
      if (in_ready !== 4'b0000 || in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", i, in_ready);
      end
      next_edge();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=3C ch=0",
                 i, out_valid, out_data, out_ch);
      end
    end
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_data[7:0] = 8'hC3;
    settle();
    n_tests++;
    if (in_ready !== 4'b0001 || in_ready !== exp_ready) begin
      n_fail++;
      $display("[TB] FAIL bp_release_ready: got %b expected 0001", in_ready);
    end
    next_edge();
    w = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_data !== w.data || out_ch !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL bp_release_word: got v=%b d=%h expected v=1 d=C3", out_valid, out_data);
    end
    in_data[7:0] = 8'h3C;
  endtask

  task automatic test_ptr_kept();
    word_t w;
    int exp_seq[2] = '{2, 3};
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      next_edge();
      w = sb.pop_front();
      n_tests++;
      if (out_ch !== 2'(exp_seq[i]) || out_ch !== w.ch || out_data !== w.data) begin
        n_fail++;
        $display("[TB] FAIL ptr_kept[%0d]: got ch=%0d d=%h expected ch=%0d d=%h",
                 i, out_ch, out_data, exp_seq[i], w.data);
      end
    end
  endtask

  task automatic test_drain();
    mode = 1'b0; sel = 2'd1; in_valid = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL drain_ready[%0d]: got %b expected 0000", i, in_ready);
      end
      next_edge();
      n_tests++;
      if (out_valid !== 1'b0 || out_valid !== m_valid) begin
        n_fail++;
        $display("[TB] FAIL drain_valid[%0d]: got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_boundary();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (in_ready3 !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL oor_ready[%0d]: got %b expected 000", i, in_ready3);
      end
      next_edge();
      n_tests++;
      if (out_valid3 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL oor_valid[%0d]: got %b expected 0", i, out_valid3);
      end
    end
    sel3 = 2'd1;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL sel1_ready: got %b expected 010", in_ready3);
    end
    next_edge();
    n_tests++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h22 || out_ch3 !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL sel1_word: got v=%b d=%h ch=%0d expected v=1 d=22 ch=1",
               out_valid3, out_data3, out_ch3);
    end
    out_ready3 = 1'b0;
    #2;
    rst3 = 1'b1;
    #1;
    n_tests++;
    if (out_valid3 !== 1'b0 || out_data3 !== 8'h00 || in_ready3 !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got v=%b d=%h rdy=%b expected v=0 d=00 rdy=000",
               out_valid3, out_data3, in_ready3);
    end
    next_edge();
    rst3 = 1'b0;
    mode3 = 1'b1; sel3 = 2'd0; out_ready3 = 1'b1;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL rr_after_reset_ready: got %b expected 001", in_ready3);
    end
    next_edge();
    n_tests++;
    if (out_valid3 !== 1'b1 || out_ch3 !== 2'd0 || out_data3 !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL rr_after_reset_word: got v=%b ch=%0d d=%h expected v=1 ch=0 d=11",
               out_valid3, out_ch3, out_data3);
    end
    next_edge();
    n_tests++;
    if (out_ch3 !== 2'd1 || out_data3 !== 8'h22) begin
      n_fail++;
      $display("[TB] FAIL rr3_second: got ch=%0d d=%h expected ch=1 d=22", out_ch3, out_data3);
    end
  endtask

`ifdef SCALE_MUX_RR_STATS_EN
  task automatic test_stats();
    do_reset();
    n_tests++;
    if (xfer_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL stats_reset: got x=%0d s=%0d expected 0/0", xfer_cnt, stall_cnt);
    end
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) next_edge();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) next_edge();
    in_valid = 4'h0;
    next_edge();
    n_tests++;
    if (xfer_cnt !== 16'd10 || stall_cnt !== 16'd4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stats_counts: got x=%0d s=%0d v=%b expected x=10 s=4 v=0",
               xfer_cnt, stall_cnt, out_valid);
    end
    in_valid = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 70001; i++) next_edge();
    n_tests++;
    if (stall_cnt !== 16'hFFFF || xfer_cnt !== 16'd10) begin
      n_fail++;
      $display("[TB] FAIL stats_saturate: got s=%h x=%0d expected s=FFFF x=10",
               stall_cnt, xfer_cnt);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_round_robin();
    test_skip_idle();
    test_back_pressure();
    test_ptr_kept();
    test_drain();
    test_boundary();
`ifdef SCALE_MUX_RR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
